// File: rtl/w65_bus_pkg.sv
// w65_bus_pkg: shared types and memory-map constants for the 65C816 bus initiator
package w65_bus_pkg;
  typedef enum logic [1:0] {IDLE, PH1, PH2} state_t;
  typedef struct packed {
    logic [23:0] addr;
    logic        rwb;
    logic [7:0]  wdata;
    logic        vpa;
    logic        vda;
  } txn_t;
  localparam logic [15:0] ROM_BASE  = 16'hC000;
  localparam logic [15:0] RAM_TOP   = 16'h8000;
  localparam logic [15:0] ACIA_BASE = 16'h8000;
  localparam logic [15:0] ACIA_TOP  = 16'h8010;
endpackage

// File: rtl/w65_phase_gen.sv
// w65_phase_gen: free-running PHI2 phase counter with phase-boundary strobes and stall hold
module w65_phase_gen #(
  parameter int PH1_CYCLES = 4,
  parameter int PH2_CYCLES = 4
) (
  input  logic CLK,
  input  logic RESB,
  input  logic stall,
  output logic phi2,
  output logic last_ph1,
  output logic first_ph2,
  output logic last_ph2
);
  localparam int TOT = PH1_CYCLES + PH2_CYCLES;
  localparam int CW  = $clog2(TOT);
  logic [CW-1:0] cnt, cnt_nx;
  assign last_ph1  = cnt == CW'(PH1_CYCLES - 1);
  assign first_ph2 = cnt == CW'(PH1_CYCLES);
  assign last_ph2  = cnt == CW'(TOT - 1);
  assign cnt_nx    = stall ? cnt : last_ph2 ? '0 : cnt + 1'b1;
  // PHI2 is registered from the next count so the pin never glitches on a decode
  always_ff @(posedge CLK or negedge RESB)
    if (!RESB) begin
      cnt  <= '0;
      phi2 <= 1'b0;
    end else begin
      cnt  <= cnt_nx;
      phi2 <= cnt_nx >= CW'(PH1_CYCLES);
    end
endmodule

// File: rtl/w65_bus_initiator.sv
// w65_bus_initiator: 65C816 bus master running single read/write cycles from a valid/ready port.
// Define W65_RDY_STALL_EN to let RDY=0 stretch PHI2-high at the end of a cycle.
module w65_bus_initiator
  import w65_bus_pkg::*;
#(
  parameter int PH1_CYCLES = 4,
  parameter int PH2_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RESB,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  input  logic        req_rwb,
  input  logic [7:0]  req_wdata,
  input  logic        req_vpa,
  input  logic        req_vda,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        PHI2,
  output logic [15:0] A,
  output logic        RWB,
  output logic        VDA,
  output logic        VPA,
  output logic [7:0]  d_out,
  output logic        d_oe,
  input  logic [7:0]  d_in,
  input  logic        RDY
);
  state_t state, state_nx;
  txn_t   txn;
  logic   last_ph1, first_ph2, last_ph2, stall, done;
`ifdef W65_RDY_STALL_EN
  assign stall = last_ph2 && !RDY;
`else
  logic rdy_unused;
  assign stall      = 1'b0;
  assign rdy_unused = RDY;
`endif
  w65_phase_gen #(.PH1_CYCLES(PH1_CYCLES), .PH2_CYCLES(PH2_CYCLES)) u_phase (
    .CLK       (CLK),
    .RESB      (RESB),
    .stall     (stall),
    .phi2      (PHI2),
    .last_ph1  (last_ph1),
    .first_ph2 (first_ph2),
    .last_ph2  (last_ph2)
  );
  assign req_ready = last_ph2 && !stall;
  assign done      = req_ready && state == PH2;
  always_comb
    state_nx = req_ready ? (req_valid ? PH1 : IDLE) : (state == PH1 && last_ph1) ? PH2 : state;
  always_ff @(posedge CLK or negedge RESB)
    if (!RESB) begin
      state     <= IDLE;
      txn       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nx;
      rsp_valid <= done;
      if (req_ready && req_valid) txn <= '{req_addr, req_rwb, req_wdata, req_vpa, req_vda};
      if (done && txn.rwb) rsp_rdata <= d_in;
    end
  // The txn register doubles as the bus hold; IDLE only masks the control strobes
  assign A     = txn.addr[15:0];
  assign RWB   = state == IDLE ? 1'b1 : txn.rwb;
  assign VDA   = state != IDLE && txn.vda;
  assign VPA   = state != IDLE && txn.vpa;
  assign d_oe  = (state == PH1 && !last_ph1) || (state == PH2 && !txn.rwb && !first_ph2);
  assign d_out = d_oe ? (state == PH1 ? txn.addr[23:16] : txn.wdata) : '0;
endmodule

// File: tb/tb_w65_bus_initiator.sv
// tb_w65_bus_initiator: scoreboard bench for w65_bus_initiator with a small bus-side memory model.
module tb_w65_bus_initiator;
  import w65_bus_pkg::*;
  logic        CLK = 1'b0, RESB = 1'b0, req_valid = 1'b0, req_rwb = 1'b1, req_vpa = 1'b0, req_vda = 1'b0, RDY = 1'b1;
  logic [23:0] req_addr = '0;
  logic [7:0]  req_wdata = '0, d_in = '0;
  logic        req_ready, rsp_valid, PHI2, RWB, VDA, VPA, d_oe;
  logic [7:0]  rsp_rdata, d_out;
  logic [15:0] A;
  w65_bus_initiator #(.PH1_CYCLES(4), .PH2_CYCLES(4)) dut (
    .CLK(CLK), .RESB(RESB), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_rwb(req_rwb), .req_wdata(req_wdata), .req_vpa(req_vpa), .req_vda(req_vda),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .PHI2(PHI2), .A(A), .RWB(RWB), .VDA(VDA),
    .VPA(VPA), .d_out(d_out), .d_oe(d_oe), .d_in(d_in), .RDY(RDY)
  );
  always #5 CLK = ~CLK;
  typedef struct packed {logic rd; logic [7:0] data;} exp_t;
  exp_t        sb[$];
  exp_t        sb_e;
  int          vectors = 0, errors = 0, rsp_n = 0, cyc = 0;
  int          rsp_cyc[$];
  logic [7:0]  bus_mem[bit [23:0]];
  logic [7:0]  exp_mem[bit [23:0]];
  logic [7:0]  bank_q = '0;
  function automatic logic [7:0] init_val(input logic [23:0] a);
    if (a[15:0] == ROM_BASE) return 8'hEA;
    if (a[15:0] > ROM_BASE) return a[7:0] ^ a[15:8];
    if (a[15:0] >= ACIA_BASE && a[15:0] < ACIA_TOP) return 8'h10;
    if (a[15:0] < RAM_TOP) return 8'h00;
    return 8'hFF;
  endfunction
  always @(posedge CLK) cyc <= cyc + 1;
  // Responder side: latch bank in PH1, commit writes and drive reads in PH2
  always @(negedge CLK) begin
    if (!PHI2 && d_oe) bank_q = d_out;
    if (PHI2 && d_oe && !RWB) bus_mem[{bank_q, A}] = d_out;
    d_in = (PHI2 && RWB) ? (bus_mem.exists({bank_q, A}) ? bus_mem[{bank_q, A}] : init_val({bank_q, A})) : 8'h00;
  end
  always @(negedge CLK)
    if (rsp_valid) begin
      rsp_n++;
      rsp_cyc.push_back(cyc);
      vectors++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got rsp_valid rdata=%h, none outstanding", rsp_rdata);
      end else begin
        sb_e = sb.pop_front();
        if (sb_e.rd && rsp_rdata !== sb_e.data) begin
          errors++;
          $display("FAIL rsp_rdata: got %h expected %h", rsp_rdata, sb_e.data);
        end
      end
    end
  task automatic issue(input logic [23:0] a, input logic rwb, input logic [7:0] wd,
                       input logic vpa, input logic vda, input bit hold, output int waited);
    req_addr = a; req_rwb = rwb; req_wdata = wd; req_vpa = vpa; req_vda = vda; req_valid = 1'b1;
    waited = 0;
    while (1) begin
      @(negedge CLK);
      waited++;
      if (req_ready) break;
      if (waited >= 64) begin
        vectors++; errors++;
        $display("FAIL issue_timeout: req_ready=%b after %0d clocks, expected 1", req_ready, waited);
        req_valid = 1'b0;
        return;
      end
    end
    if (rwb) sb.push_back('{1'b1, exp_mem.exists(a) ? exp_mem[a] : init_val(a)});
    else begin
      sb.push_back('{1'b0, 8'h00});
      exp_mem[a] = wd;
    end
    @(posedge CLK); #1;
    if (!hold) req_valid = 1'b0;
  endtask
  task automatic test_reset;
    logic [38:0] got;
    repeat (3) @(posedge CLK);
    #1;
    got = {PHI2, A, d_out, d_oe, RWB, VDA, VPA, req_ready, rsp_valid, rsp_rdata};
    vectors++;
    if (got !== {1'b0, 16'h0, 8'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0}) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", got, {1'b0, 16'h0, 8'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0});
    end
    RESB = 1'b1;
  endtask
  task automatic test_idle;
    logic [5:0] got, exp;
    for (int k = 0; k < 16; k++) begin
      got = {PHI2, req_ready, VDA, VPA, RWB, d_oe};
      exp = {(k % 8) >= 4, (k % 8) == 7, 1'b0, 1'b0, 1'b1, 1'b0};
      vectors++;
      if (got !== exp) begin
        errors++;
        $display("FAIL idle_k%0d: got %b expected %b", k, got, exp);
      end
      @(posedge CLK); #1;
    end
  endtask
  task automatic test_write;
    int w;
    logic [30:0] got, exp;
    issue(24'h128003, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, w);
    for (int k = 0; k <= 8; k++) begin
      got = {PHI2, A, RWB, VDA, VPA, d_oe, d_out, rsp_valid};
      exp = {k >= 4 && k < 8, 16'h8003, k == 8, k < 8, 1'b0, k < 3 || (k >= 5 && k < 8),
             k < 3 ? 8'h12 : (k >= 5 && k < 8) ? 8'h5A : 8'h00, k == 8};
      vectors++;
      if (got !== exp) begin
        errors++;
        $display("FAIL write_k%0d: got %h expected %h", k, got, exp);
      end
      @(posedge CLK); #1;
    end
  endtask
  task automatic test_read;
    int w;
    logic [38:0] got, exp;
    issue(24'h00C000, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, w);
    for (int k = 0; k <= 8; k++) begin
      got = {PHI2, A, RWB, VDA, VPA, d_oe, d_out, rsp_valid, k == 8 ? rsp_rdata : 8'h00};
      exp = {k >= 4 && k < 8, 16'hC000, 1'b1, k < 8, k < 8, k < 3, 8'h00, k == 8, k == 8 ? 8'hEA : 8'h00};
      vectors++;
      if (got !== exp) begin
        errors++;
        $display("FAIL read_k%0d: got %h expected %h", k, got, exp);
      end
      @(posedge CLK); #1;
    end
  endtask
  task automatic test_back_to_back;
    int w, n0, gap;
    n0 = rsp_n;
    issue(24'h000010, 1'b0, 8'h77, 1'b0, 1'b1, 1'b1, w);
    issue(24'h000010, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, w);
    vectors++;
    if (w !== 8) begin
      errors++;
      $display("FAIL b2b_accept_gap: got %0d clocks expected 8", w);
    end
    repeat (10) @(posedge CLK);
    #1;
    gap = rsp_n - n0 == 2 ? rsp_cyc[rsp_cyc.size()-1] - rsp_cyc[rsp_cyc.size()-2] : -1;
    vectors++;
    if (rsp_n - n0 != 2 || gap != 8) begin
      errors++;
      $display("FAIL b2b_rsp: got %0d pulses gap %0d expected 2 pulses gap 8", rsp_n - n0, gap);
    end
  endtask
  task automatic test_reset_midcycle;
    int w, n0;
    logic [38:0] got;
    issue(24'h000020, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0, w);
    repeat (5) @(posedge CLK);
    #1;
    RESB = 1'b0;
    #1;
    got = {PHI2, A, d_out, d_oe, RWB, VDA, VPA, req_ready, rsp_valid, rsp_rdata};
    vectors++;
    if (got !== {1'b0, 16'h0, 8'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0}) begin
      errors++;
      $display("FAIL midcycle_reset: got %h expected %h", got, {1'b0, 16'h0, 8'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0});
    end
    sb.delete();
    n0 = rsp_n;
    repeat (2) @(posedge CLK);
    #1;
    RESB = 1'b1;
    issue(24'h000010, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, w);
    vectors++;
    if (w !== 8) begin
      errors++;
      $display("FAIL post_reset_accept: got %0d clocks expected 8", w);
    end
    repeat (10) @(posedge CLK);
    #1;
    vectors++;
    if (rsp_n - n0 != 1) begin
      errors++;
      $display("FAIL post_reset_rsp_count: got %0d expected 1", rsp_n - n0);
    end
  endtask
  task automatic test_rdy;
    int w, n0, run, rsp_k, rdy_leak;
    bit run_done;
    issue(24'h00C005, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, w);
    n0 = rsp_n; run = 0; run_done = 0; rsp_k = -1; rdy_leak = 0;
    for (int k = 0; k < 20; k++) begin
      if (PHI2 && !run_done) run++;
      else if (run > 0) run_done = 1;
      if (rsp_valid && rsp_k < 0) rsp_k = k;
      if (k >= 8 && k <= 12 && req_ready) rdy_leak++;
      if (k == 7) RDY = 1'b0;
      if (k == 12) RDY = 1'b1;
      @(posedge CLK); #1;
    end
`ifdef W65_RDY_STALL_EN
    vectors++;
    if (run != 9 || rsp_k != 13 || rdy_leak != 0) begin
      errors++;
      $display("FAIL rdy_stall: got high=%0d rsp_at=%0d ready_leaks=%0d expected 9/13/0", run, rsp_k, rdy_leak);
    end
`else
    vectors++;
    if (run != 4 || rsp_k != 8) begin
      errors++;
      $display("FAIL rdy_ignored: got high=%0d rsp_at=%0d expected 4/8", run, rsp_k);
    end
`endif
    vectors++;
    if (rsp_n - n0 != 1) begin
      errors++;
      $display("FAIL rdy_rsp_count: got %0d expected 1", rsp_n - n0);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_idle();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_midcycle();
    test_rdy();
    vectors++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d outstanding expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
